// File: rtl/timebase_pkg.sv
// Shared types, default 12 MHz divisors and divisor slicing for the timebase block.
package timebase_pkg;

  typedef enum logic {
    IRQ_PULSE = 1'b0,
    IRQ_LEVEL = 1'b1
  } irq_mode_e;

  localparam int unsigned MAX_VEC_W = 32'd256;

  localparam int unsigned DIV_3MHZ = 32'd4;
  localparam int unsigned DIV_6MHZ = 32'd2;
  localparam int unsigned DIV_3KHZ = 32'd4000;
  localparam int unsigned DIV_6KHZ = 32'd2000;

  // Extracts divisor i from a packed vector of cnt_w-wide fields.
  function automatic logic [31:0] div_of(input logic [MAX_VEC_W-1:0] vec,
                                         input int unsigned i,
                                         input int unsigned cnt_w);
    logic [MAX_VEC_W-1:0] sh;
    sh = vec >> (i * cnt_w);
    sh = sh & ((MAX_VEC_W'(1) << cnt_w) - MAX_VEC_W'(1));
    return sh[31:0];
  endfunction

endpackage

// File: rtl/timebase_ch.sv
// One divider channel: wrapping counter with registered enable strobe and square-wave phase.
module timebase_ch
  import timebase_pkg::*;
#(
  parameter int unsigned     CNT_W = 16,
  parameter logic [CNT_W-1:0] DIV  = CNT_W'(1)
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic resync,
  output logic en_o,
  output logic phase_o
);

  localparam logic [CNT_W-1:0] LAST = DIV - CNT_W'(1);
  localparam logic [CNT_W-1:0] HALF = DIV >> 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             en_q, en_d;
  logic             phase_q, phase_d;

  // Next-state: disabled channel stays dark, resync beats run, stalled channel holds phase.
  always_comb begin
    cnt_d   = cnt_q;
    en_d    = 1'b0;
    phase_d = phase_q;
    if (DIV == CNT_W'(0)) begin
      cnt_d   = CNT_W'(0);
      phase_d = 1'b0;
    end else if (resync) begin
      cnt_d   = CNT_W'(0);
      phase_d = (HALF == CNT_W'(0));
    end else if (run) begin
      en_d    = (cnt_q == LAST);
      phase_d = (cnt_q >= HALF);
      if (cnt_q == LAST) begin
        cnt_d = CNT_W'(0);
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Channel state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= CNT_W'(0);
      en_q    <= 1'b0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      phase_q <= phase_d;
    end
  end

  assign en_o    = en_q;
  assign phase_o = phase_q;

endmodule

// File: rtl/timebase_gen.sv
// Multi-channel timebase: N_CH divider channels plus a periodic interrupt counted
// from the strobes of channel IRQ_SRC.
module timebase_gen
  import timebase_pkg::*;
#(
  parameter int unsigned          N_CH     = 4,
  parameter int unsigned          CNT_W    = 16,
  parameter logic [N_CH*CNT_W-1:0] DIV_VEC = {16'd8192, 16'd4096, 16'd8, 16'd16},
  parameter int unsigned          IRQ_SRC  = 3,
  parameter int unsigned          IRQ_DIV  = 14,
  parameter irq_mode_e            IRQ_MODE = IRQ_PULSE
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  input  logic            resync,
  input  logic            irq_ack,
  output logic [N_CH-1:0] en_o,
  output logic [N_CH-1:0] phase_o,
  output logic            irq_o,
  output logic            irq_overrun
);

  // Divisors cannot exceed 2^CNT_W-1: each one is a CNT_W-bit field of DIV_VEC.
  if (N_CH < 1 || N_CH > 16) begin : g_err_nch
    $error("timebase_gen: N_CH must be 1..16");
  end
  if (CNT_W < 1 || CNT_W > 32 || N_CH * CNT_W > MAX_VEC_W) begin : g_err_cntw
    $error("timebase_gen: unsupported CNT_W");
  end
  if (IRQ_SRC >= N_CH) begin : g_err_src
    $error("timebase_gen: IRQ_SRC must be below N_CH");
  end
  if (IRQ_DIV < 2 || IRQ_DIV > 255) begin : g_err_div
    $error("timebase_gen: IRQ_DIV must be 2..255");
  end

  localparam logic [MAX_VEC_W-1:0] DIV_EXT   = MAX_VEC_W'(DIV_VEC);
  localparam logic [7:0]           ICNT_LAST = 8'(IRQ_DIV - 1);

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    localparam logic [CNT_W-1:0] DIV_G = CNT_W'(div_of(DIV_EXT, g, CNT_W));
    timebase_ch #(
      .CNT_W (CNT_W),
      .DIV   (DIV_G)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .run     (run),
      .resync  (resync),
      .en_o    (en_o[g]),
      .phase_o (phase_o[g])
    );
  end

  logic [7:0] icnt_q, icnt_d;
  logic       irq_q, irq_d;
  logic       ovr_q, ovr_d;
  logic       src_s, ev_s;

  assign src_s = en_o[IRQ_SRC];

  // Counts source strobes; the wrap back to zero is the interrupt event.
  always_comb begin
    icnt_d = icnt_q;
    ev_s   = 1'b0;
    if (src_s) begin
      if (icnt_q == ICNT_LAST) begin
        icnt_d = 8'd0;
        ev_s   = 1'b1;
      end else begin
        icnt_d = icnt_q + 8'd1;
      end
    end else begin
      icnt_d = icnt_q;
    end
  end

  // Pulse mode mirrors the event; level mode latches it until acknowledged.
  always_comb begin
    irq_d = irq_q;
    ovr_d = ovr_q;
    if (IRQ_MODE == IRQ_LEVEL) begin
      if (ev_s) begin
        irq_d = 1'b1;
      end else if (irq_ack) begin
        irq_d = 1'b0;
      end else begin
        irq_d = irq_q;
      end
      ovr_d = ovr_q | (ev_s & irq_q & ~irq_ack);
    end else begin
      irq_d = ev_s;
      ovr_d = 1'b0;
    end
  end

  // Interrupt state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      icnt_q <= 8'd0;
      irq_q  <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      icnt_q <= icnt_d;
      irq_q  <= irq_d;
      ovr_q  <= ovr_d;
    end
  end

  assign irq_o       = irq_q;
  assign irq_overrun = ovr_q;

endmodule

// File: tb/tb_timebase_gen.sv
// Directed bench for timebase_gen: a pulse-mode and a level-mode instance checked
// every cycle against an arithmetic model plus hand-computed spot values.
module tb_timebase_gen;
  import timebase_pkg::*;

  logic clk = 1'b0;
  logic rst, run, resync, irq_ack;
  logic [3:0] en_p, ph_p, en_l, ph_l;
  logic irq_p, ovr_p, irq_l, ovr_l;

  always #5 clk = ~clk;

  // ch0=8, ch1=4, ch2=2, ch3=1 (pulse); ch2 disabled in the level instance
  timebase_gen #(
    .N_CH(4), .CNT_W(16), .DIV_VEC({16'd1, 16'd2, 16'd4, 16'd8}),
    .IRQ_SRC(1), .IRQ_DIV(3), .IRQ_MODE(IRQ_PULSE)
  ) u_pulse (
    .clk(clk), .rst(rst), .run(run), .resync(resync), .irq_ack(irq_ack),
    .en_o(en_p), .phase_o(ph_p), .irq_o(irq_p), .irq_overrun(ovr_p)
  );

  timebase_gen #(
    .N_CH(4), .CNT_W(16), .DIV_VEC({16'd1, 16'd0, 16'd4, 16'd8}),
    .IRQ_SRC(1), .IRQ_DIV(3), .IRQ_MODE(IRQ_LEVEL)
  ) u_level (
    .clk(clk), .rst(rst), .run(run), .resync(resync), .irq_ack(irq_ack),
    .en_o(en_l), .phase_o(ph_l), .irq_o(irq_l), .irq_overrun(ovr_l)
  );

  int checks = 0;
  int failures = 0;

  // Model: n = advancing edges since last clear; strobes = source strobes since reset.
  int divs [2][4];
  int n [2][4];
  int strobes [2];
  logic [3:0] m_en [2];
  logic [3:0] m_ph [2];
  logic m_irq [2];
  logic m_ovr [2];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    logic ev;
    int d;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_en[k] = 4'd0; m_ph[k] = 4'd0; m_irq[k] = 1'b0; m_ovr[k] = 1'b0;
        strobes[k] = 0;
        for (int i = 0; i < 4; i++) n[k][i] = 0;
      end else begin
        ev = 1'b0;
        if (m_en[k][1]) begin
          strobes[k]++;
          ev = (strobes[k] % 3 == 0);
        end
        if (k == 0) begin
          m_irq[k] = ev;
        end else begin
          if (ev && m_irq[k] && !irq_ack) m_ovr[k] = 1'b1;
          m_irq[k] = ev || (m_irq[k] && !irq_ack);
        end
        for (int i = 0; i < 4; i++) begin
          d = divs[k][i];
          if (d == 0) begin
            n[k][i] = 0; m_en[k][i] = 1'b0; m_ph[k][i] = 1'b0;
          end else if (resync) begin
            n[k][i] = 0; m_en[k][i] = 1'b0; m_ph[k][i] = (d == 1);
          end else if (run) begin
            n[k][i]++;
            m_en[k][i] = (n[k][i] % d == 0);
            m_ph[k][i] = (((n[k][i] - 1) % d) >= d / 2);
          end else begin
            m_en[k][i] = 1'b0;
          end
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("en_pulse", int'(en_p), int'(m_en[0]));
    chk("phase_pulse", int'(ph_p), int'(m_ph[0]));
    chk("irq_pulse", int'(irq_p), int'(m_irq[0]));
    chk("ovr_pulse", int'(ovr_p), int'(m_ovr[0]));
    chk("en_level", int'(en_l), int'(m_en[1]));
    chk("phase_level", int'(ph_l), int'(m_ph[1]));
    chk("irq_level", int'(irq_l), int'(m_irq[1]));
    chk("ovr_level", int'(ovr_l), int'(m_ovr[1]));
  endtask

  initial begin
    int lat;
    divs[0] = '{8, 4, 2, 1};
    divs[1] = '{8, 4, 0, 1};
    for (int k = 0; k < 2; k++) begin
      m_en[k] = 4'd0; m_ph[k] = 4'd0; m_irq[k] = 1'b0; m_ovr[k] = 1'b0;
      strobes[k] = 0;
      for (int i = 0; i < 4; i++) n[k][i] = 0;
    end
    rst = 1'b1; run = 1'b0; resync = 1'b0; irq_ack = 1'b0;
    step();
    step();
    chk("rst_en", int'(en_p | en_l), 0);
    chk("rst_phase", int'(ph_p | ph_l), 0);
    chk("rst_irq", int'({irq_p, ovr_p, irq_l, ovr_l}), 0);

    rst = 1'b0; run = 1'b1;
    for (int e = 1; e <= 40; e++) begin
      irq_ack = (e == 37 || e == 39);
      step();
      chk("ch2_disabled", int'({en_l[2], ph_l[2]}), 0);
      if (e == 3) begin
        chk("e3_en", int'(en_p), 4'b1000);
        chk("e3_phase", int'(ph_p), 4'b1010);
      end
      if (e == 4) begin
        chk("e4_en", int'(en_p), 4'b1110);
        chk("e4_phase", int'(ph_p), 4'b1110);
      end
      if (e == 8) begin
        chk("e8_en_pulse", int'(en_p), 4'b1111);
        chk("e8_en_level", int'(en_l), 4'b1011);
      end
      if (e == 12) chk("e12_irq_p", int'(irq_p), 0);
      if (e == 13) begin
        chk("e13_irq_p", int'(irq_p), 1);
        chk("e13_irq_l", int'(irq_l), 1);
      end
      if (e == 14) chk("e14_irq_p", int'(irq_p), 0);
      if (e == 24) chk("e24_ovr_l", int'(ovr_l), 0);
      if (e == 25) begin
        chk("e25_irq_p", int'(irq_p), 1);
        chk("e25_ovr_l", int'(ovr_l), 1);
      end
      if (e == 37) chk("e37_ack_event", int'(irq_l), 1);
      if (e == 38) chk("e38_irq_l", int'(irq_l), 1);
      if (e == 39) chk("e39_acked", int'(irq_l), 0);
      if (e == 40) chk("e40_ovr_p", int'(ovr_p), 0);
    end
    irq_ack = 1'b0;
    step();
    step();

    // ch1 counter sits at 2 here
    run = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("gap_no_strobe", int'(en_p), 0);
    end
    run = 1'b1;
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (en_p[1]) begin
        lat = k;
        break;
      end
    end
    chk("gap_latency", lat, 2);

    for (int k = 0; k < 16 && (n[0][0] % 8) != 5; k++) step();
    resync = 1'b1;
    step();
    chk("resync_en", int'(en_p), 0);
    resync = 1'b0;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (en_p[0]) begin
        lat = k;
        break;
      end
    end
    chk("resync_latency", lat, 8);

    for (int e = 0; e < 24; e++) begin
      irq_ack = (e % 7 == 3);
      run = (e % 9 != 5);
      step();
    end

    rst = 1'b1; run = 1'b1; resync = 1'b1; irq_ack = 1'b1;
    step();
    chk("midrst_en", int'(en_p | en_l), 0);
    chk("midrst_phase", int'(ph_p | ph_l), 0);
    chk("midrst_irq", int'({irq_p, ovr_p, irq_l, ovr_l}), 0);
    rst = 1'b0; resync = 1'b0; irq_ack = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      step();
      if (e == 4) chk("post_rst_e4", int'(en_l), 4'b1010);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
